// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter and sequencer for one shared resource.
// It grants one requester at a time, limits each grant to MAX_HOLD cycles,
// and passes through IDLE between grants. Per-requester wait counters raise
// sticky starvation flags.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; pick the first requester at/after ptr (wrapping)
//   ACTIVE| grant held; leave on done/req drop, or when hold hits MAX_HOLD
//   WAIT  | forced revoke cycle after a full-length hold
//   DONE  | grant released; advance ptr past the last grantee
module rr_resource_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int MAX_WAIT = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       ack,
    output logic [2:0]                 state,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         starve_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = IDW + 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int WW  = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_ACTIVE = 3'b001;
    localparam logic [2:0] ST_WAIT   = 3'b010;
    localparam logic [2:0] ST_DONE   = 3'b011;

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       ptr_next;
    logic [IDW-1:0]       sel_idx;
    logic                 sel_found;
    logic [SW-1:0]        sel_sum;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [HW-1:0]        hold;
    logic                 release_req;
    logic [WW-1:0]        wait_cnt [NUM_REQ];

    // Rotate req so bit 0 is the requester at ptr, then take the lowest set bit
    // and map it back to an absolute index.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[NUM_REQ-1:0];
        sel_found = |req_rot;
        sel_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_sum = {1'b0, ptr} + SW'(k);
            end
        end
        if (sel_sum >= SW'(NUM_REQ)) begin
            sel_idx = IDW'(sel_sum - SW'(NUM_REQ));
        end else begin
            sel_idx = IDW'(sel_sum);
        end
    end

    // Holder release condition and the pointer value after this grant.
    always_comb begin
        release_req = done[grant_id] | ~req[grant_id];
        if (grant_id == IDW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_id + 1'b1;
        end
    end

    // Grant and busy are decoded from state so they can never disagree with it.
    always_comb begin
        grant = (state == ST_ACTIVE) ? (NUM_REQ'(1) << grant_id) : '0;
        busy  = (state == ST_ACTIVE) || (state == ST_WAIT);
    end

    // Sequencer: selection, hold limit, revoke and pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            ack      <= 1'b0;
            ptr      <= '0;
            hold     <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state    <= ST_ACTIVE;
                        grant_id <= sel_idx;
                        ack      <= 1'b1;
                        hold     <= HW'(1);
                    end
                end
                ST_ACTIVE: begin
                    // Release beats the hold limit when both happen together.
                    if (release_req) begin
                        state <= ST_DONE;
                    end else if (hold == HW'(MAX_HOLD)) begin
                        state <= ST_WAIT;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                ST_WAIT: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ptr   <= ptr_next;
                    hold  <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating wait counters; the flag latches on the edge the count hits MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_err <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WW'(MAX_WAIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    if (wait_cnt[i] == WW'(MAX_WAIT - 1)) begin
                        starve_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one resource among NUM_REQ requesters.
- Grants one requester at a time, bounds how long each grant lasts, and returns to IDLE between grants.
- Tracks wait time per requester and flags starvation.
- Sits in front of the shared resource; its state, ack, busy and grant signals are the ones the liveness checkers observe.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_HOLD, 16: maximum cycles a grant stays asserted before forced release (>=1).
- MAX_WAIT, 100: starvation threshold in waiting cycles (>=1).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  request vector; holder keeps req high while using the resource.
- done  input  NUM_REQ  release pulse from requesters; only the bit of the current grant holder is honoured.
- grant  output  NUM_REQ  one-hot or zero grant vector.
- grant_id  output  $clog2(NUM_REQ)  index of current/last grantee.
- ack  output  1  single-cycle pulse on the first cycle of each grant.
- state  output  3  FSM state: IDLE=000, ACTIVE=001, WAIT=010, DONE=011.
- busy  output  1  high in ACTIVE or WAIT.
- starve_err  output  NUM_REQ  sticky per-requester starvation flags.

Behaviour:
- Reset (rst high at posedge), effective at that edge even mid-grant:
  - state=IDLE; grant=0; ack=0; busy=0; grant_id=0; starve_err=0.
  - Priority pointer ptr=0; hold counter=0; all wait counters=0.
- IDLE:
  - If req==0: stay in IDLE, ptr unchanged.
  - Otherwise select the first set req bit at or after ptr, wrapping modulo NUM_REQ.
  - Next cycle: state=ACTIVE, grant=onehot(sel), grant_id=sel, ack=1, hold=1.
- ACTIVE: grant held; ack is 0 after the first cycle; hold increments each cycle.
  - Exit priority, evaluated each cycle:
    1. done[grant_id]==1 or req[grant_id]==0 -> DONE.
    2. else hold==MAX_HOLD -> WAIT (forced preemption).
    3. else stay in ACTIVE.
  - grant is therefore high for at most MAX_HOLD cycles.
- WAIT: grant=0; one revoke cycle; -> DONE unconditionally.
- DONE: grant=0; ptr <= (grant_id+1) mod NUM_REQ; -> IDLE unconditionally.
- Turnaround:
  - IDLE->ACTIVE latency is 1 cycle.
  - Worst-case per-grant slot is MAX_HOLD+3 cycles (IDLE, ACTIVE×MAX_HOLD, WAIT, DONE).
  - Normal release uses MAX_HOLD+2 or fewer cycles.
- Ignored inputs:
  - done bits for non-granted indices: no effect.
  - done in IDLE, WAIT or DONE: no effect.
  - req rising in WAIT or DONE: considered at the next IDLE.
- Simultaneous events: done and hold==MAX_HOLD in the same cycle -> DONE (release wins, no WAIT).
- Wait counter i (width $clog2(MAX_WAIT+1), saturating):
  - Increments when req[i]=1 and grant[i]=0.
  - Clears when req[i]=0 or grant[i]=1.
  - When it reaches MAX_WAIT, starve_err[i] sets; it clears only on rst.
- Fairness guarantee:
  - Any continuously requesting index is granted after at most (NUM_REQ-1)*(MAX_HOLD+3)+1 waiting cycles (58 with defaults).
  - With defaults, starve_err never sets.
- Output invariants:
  - grant is never multi-hot.
  - grant!=0 only in ACTIVE.
  - ack implies grant!=0.
  - busy == (state==ACTIVE || state==WAIT).

Test Plan:
- Single grant: out of reset, req=0010 in cycle 0.
  - Cycle 1: state=001, grant=0010, grant_id=1, ack=1.
  - done[1] pulse in cycle 3 -> cycle 4 state=011, grant=0; cycle 5 state=000; next grant starts search at index 2.
- Round robin: req=1111 held, each grantee pulses done on its 2nd grant cycle.
  - Grant order 0,1,2,3,0; each slot is 4 cycles (IDLE, ACTIVE×2, DONE).
  - ack pulses once per slot.
- Forced release: req=0001 held, done never asserted.
  - grant=0001 for exactly 16 cycles, then WAIT 1 cycle, DONE 1 cycle, IDLE.
  - Re-granted to 0 with ack=1; busy low only in DONE and IDLE.
- Starvation bound: req=1111 held, no done.
  - Requester 3 first granted after exactly 58 waiting cycles; starve_err=0000.
  - Rerun with MAX_WAIT=50: starve_err[3] sets after 50 waiting cycles and stays set after grant.
- Reset mid-grant: rst high for one edge during ACTIVE with grant=0100.
  - At that edge: state=000, grant=0, ack=0, starve_err=0.
  - Next request with req=1111 grants index 0.
- Edge inputs:
  - done[2] pulsed while index 0 holds the grant: no change.
  - req[0] dropped mid-ACTIVE: next cycle DONE, then ptr=1.
  - done and hold==16 coincide: DONE, no WAIT.
